// File: rtl/fetch_unit_pkg.sv
// Shared fetch-path constants and types: reset PC, instruction width,
// PC stride and the queued {pc, instr} record.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          INSTR_W  = 32;
  localparam logic [31:0] PC_INC   = 32'd4;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Sequential fetch address; wraps 0xFFFF_FFFC -> 0 through natural overflow.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Synchronous power-of-two FIFO with flush and occupancy count. Head reads
// straight from the storage registers and shows zero while empty.
module fetch_unit_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited in-order requests to imem,
// {pc, instr} queue toward ID, and redirect squash via a drop counter.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = fetch_unit_pkg::RESET_PC,
  parameter int          DEPTH    = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  output logic                                imem_req_valid,
  output logic [31:0]                         imem_req_addr,
  input  logic                                imem_req_ready,
  input  logic                                imem_rsp_valid,
  input  logic [fetch_unit_pkg::INSTR_W-1:0]  imem_rsp_data,
  input  logic                                redirect_valid,
  input  logic [31:0]                         redirect_pc,
  output logic                                id_valid,
  output logic [fetch_unit_pkg::INSTR_W-1:0]  id_instr,
  output logic [31:0]                         id_pc,
  input  logic                                id_ready
);

  import fetch_unit_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] infl_cnt, queue_cnt;
  logic [CW:0]   outstanding;
  logic [31:0]   infl_head;
  fetch_entry_t  queue_head, queue_push_data;
  logic          req_fire, rsp_keep, id_pop;

  // Every slot reserved by an inflight request is guaranteed room in the queue.
  assign outstanding    = {1'b0, infl_cnt} + {1'b0, queue_cnt};
  assign imem_req_valid = !reset && !redirect_valid && (outstanding < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_keep = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);
  assign id_valid = (queue_cnt != '0) && !redirect_valid;
  assign id_pop   = id_valid && id_ready;

  assign queue_push_data.pc    = infl_head;
  assign queue_push_data.instr = imem_rsp_data;
  assign id_pc                 = queue_head.pc;
  assign id_instr              = queue_head.instr;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid)  fetch_pc_d = redirect_pc;
    else if (req_fire)   fetch_pc_d = pc_next(fetch_pc_q);
  end

  // On redirect everything still outstanding is stale, minus a response landing now.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid)
      drop_cnt_d = infl_cnt - CW'(imem_rsp_valid);
    else if (imem_rsp_valid && (drop_cnt_q != '0))
      drop_cnt_d = drop_cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_unit_sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_inflight (
    .clk     (clk),
    .reset   (reset),
    .push_i  (req_fire),
    .data_i  (fetch_pc_q),
    .pop_i   (imem_rsp_valid),
    .flush_i (1'b0),
    .head_o  (infl_head),
    .count_o (infl_cnt)
  );

  fetch_unit_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rsp_keep),
    .data_i  (queue_push_data),
    .pop_i   (id_pop),
    .flush_i (redirect_valid),
    .head_o  (queue_head),
    .count_o (queue_cnt)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand-written
// redirect, wrap and request-stall sequences against a latency memory model.
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hDEAD_BEEF;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;

  fetch_unit #(
    .RESET_PC (32'h0000_3000),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_ready       (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          rv;
    logic [31:0] addr;
    bit          iv;
    logic [31:0] pc;
  } vec_t;

  pend_t       pend[$];
  vec_t        tbl[$];
  int          cyc = 0;
  int          lat = 1;
  int          tests = 0;
  int          fails = 0;
  logic        o_rv, o_iv;
  logic [31:0] o_addr, o_pc, o_instr;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ KEY;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: memory model drives the response, outputs are captured 1ns
  // after the input change, then requests/responses are booked at the edge.
  task automatic step();
    bit fire;
    if (!reset && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    o_rv    = imem_req_valid;
    o_addr  = imem_req_addr;
    o_iv    = id_valid;
    o_pc    = id_pc;
    o_instr = id_instr;
    fire    = imem_req_valid && imem_req_ready;
    @(posedge clk);
    if (reset) begin
      pend.delete();
    end else begin
      if (imem_rsp_valid) void'(pend.pop_front());
      if (fire) pend.push_back('{addr: o_addr, due: cyc + lat});
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic add(input bit rst, input bit rdy, input bit rv, input logic [31:0] a,
                     input bit iv, input logic [31:0] pc);
    tbl.push_back('{rst: rst, rdy: rdy, rv: rv, addr: a, iv: iv, pc: pc});
  endtask

  task automatic do_reset();
    reset = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic chk_id(input string tag, input bit iv, input logic [31:0] pc);
    chk({tag, ".id_valid"}, 32'(o_iv), 32'(iv));
    if (iv) begin
      chk({tag, ".id_pc"}, o_pc, pc);
      chk({tag, ".id_instr"}, o_instr, instr_of(pc));
    end
  endtask

  initial begin
    reset = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;

    // Reset, then streaming with id_ready high
    add(1,0,0,0,0,0); add(1,0,0,0,0,0);
    add(0,1,1,32'h3000,0,0);       add(0,1,1,32'h3004,0,0);
    add(0,1,1,32'h3008,1,32'h3000); add(0,1,1,32'h300C,1,32'h3004);
    add(0,1,1,32'h3010,1,32'h3008); add(0,1,1,32'h3014,1,32'h300C);
    // ID stalled: credit stops at four, then in-order drain
    add(1,0,0,0,0,0);
    add(0,0,1,32'h3000,0,0);       add(0,0,1,32'h3004,0,0);
    add(0,0,1,32'h3008,1,32'h3000); add(0,0,1,32'h300C,1,32'h3000);
    for (int i = 0; i < 6; i++) add(0,0,0,0,1,32'h3000);
    add(0,1,0,0,1,32'h3000);
    add(0,1,1,32'h3010,1,32'h3004); add(0,1,1,32'h3014,1,32'h3008);
    add(0,1,1,32'h3018,1,32'h300C); add(0,1,1,32'h301C,1,32'h3010);
    add(0,1,1,32'h3020,1,32'h3014);
    // Fill the queue, reset mid-stream, restart from RESET_PC
    add(1,0,0,0,0,0);
    add(0,0,1,32'h3000,0,0);       add(0,0,1,32'h3004,0,0);
    add(0,0,1,32'h3008,1,32'h3000); add(0,0,1,32'h300C,1,32'h3000);
    add(0,0,0,0,1,32'h3000);       add(0,0,0,0,1,32'h3000);
    add(1,1,0,0,0,0);
    add(0,1,1,32'h3000,0,0);       add(0,1,1,32'h3004,0,0);
    add(0,1,1,32'h3008,1,32'h3000);

    lat = 1;
    foreach (tbl[i]) begin
      reset = tbl[i].rst; id_ready = tbl[i].rdy;
      redirect_valid = 1'b0; imem_req_ready = 1'b1;
      step();
      chk($sformatf("vec%0d.req_valid", i), 32'(o_rv), 32'(tbl[i].rv));
      if (!tbl[i].rst) begin
        if (tbl[i].rv) chk($sformatf("vec%0d.req_addr", i), o_addr, tbl[i].addr);
        chk($sformatf("vec%0d.id_valid", i), 32'(o_iv), 32'(tbl[i].iv));
        chk($sformatf("vec%0d.id_pc", i), o_pc, tbl[i].iv ? tbl[i].pc : 32'h0);
        chk($sformatf("vec%0d.id_instr", i), o_instr, tbl[i].iv ? instr_of(tbl[i].pc) : 32'h0);
      end
    end

    // Three-cycle memory, redirect with three outstanding (one landing now)
    lat = 3;
    do_reset();
    id_ready = 1'b1;
    step(); chk("lat3.c1.addr", o_addr, 32'h3000);
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h4000;
    step(); chk("lat3.redir.req_valid", 32'(o_rv), 0); chk_id("lat3.redir", 0, 0);
    redirect_valid = 1'b0;
    step(); chk("lat3.post.req_valid", 32'(o_rv), 1); chk("lat3.post.addr", o_addr, 32'h4000);
    chk_id("lat3.c5", 0, 0);
    step(); chk_id("lat3.c6", 0, 0);
    step(); chk_id("lat3.c7", 0, 0);
    step(); chk_id("lat3.c8", 0, 0);
    step(); chk_id("lat3.c9", 1, 32'h4000);
    step(); chk_id("lat3.c10", 1, 32'h4004);

    // Redirect coinciding with a response while ID is consuming
    lat = 1;
    do_reset();
    id_ready = 1'b1;
    step(); step();
    step(); chk_id("coin.c3", 1, 32'h3000);
    redirect_valid = 1'b1; redirect_pc = 32'h5000;
    step(); chk_id("coin.redir", 0, 0); chk("coin.redir.req_valid", 32'(o_rv), 0);
    redirect_valid = 1'b0;
    step(); chk("coin.c5.addr", o_addr, 32'h5000); chk_id("coin.c5", 0, 0);
    step(); chk_id("coin.c6", 0, 0);
    step(); chk_id("coin.c7", 1, 32'h5000);
    step(); chk_id("coin.c8", 1, 32'h5004);

    // Fetch address wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step(); chk("wrap.addr0", o_addr, 32'hFFFF_FFFC); chk("wrap.rv0", 32'(o_rv), 1);
    step(); chk("wrap.addr1", o_addr, 32'h0000_0000); chk("wrap.rv1", 32'(o_rv), 1);
    step(); chk_id("wrap.id0", 1, 32'hFFFF_FFFC);
    step(); chk_id("wrap.id1", 1, 32'h0000_0000);

    // Memory back-pressure: request held with a stable address
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold%0d.rv", i), 32'(o_rv), 1);
      chk($sformatf("hold%0d.addr", i), o_addr, 32'h0000_000C);
    end
    imem_req_ready = 1'b1;
    step(); chk("hold.accept.addr", o_addr, 32'h0000_000C);
    step(); chk("hold.next.addr", o_addr, 32'h0000_0010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
